// File: rtl/fetchq_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetchq_pkg;

    // Free slots that must stay open: the current push plus the pair in flight.
    localparam int FQ_STALL_MARGIN = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        DROP = 1'b1
    } fq_state_t;

endpackage

// File: rtl/fetchq_ram.sv
// Entry storage for the fetch queue: two write ports, two asynchronous read ports.
module fetchq_ram
    import fetchq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we0,
    input  logic [AW-1:0] waddr0,
    input  fq_entry_t     wdata0,
    input  logic          we1,
    input  logic [AW-1:0] waddr1,
    input  fq_entry_t     wdata1,
    input  logic [AW-1:0] raddr0,
    input  logic [AW-1:0] raddr1,
    output fq_entry_t     rdata0,
    output fq_entry_t     rdata1
);

    fq_entry_t mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            if (we0) mem_reg[waddr0] <= wdata0;
            if (we1) mem_reg[waddr1] <= wdata1;
        end
    end

    assign rdata0 = mem_reg[raddr0];
    assign rdata1 = mem_reg[raddr1];

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch-pair queue feeding dual-issue decode, with PC stall and jump flush.
// Optional same-cycle bypass of an empty queue: define FETCHQ_BYPASS_EN.
module instr_fetch_queue
    import fetchq_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_valid,
    input  logic [31:0]                fetch_pc,
    input  logic [31:0]                fetch_instr0,
    input  logic [31:0]                fetch_instr1,
    input  logic                       jump,
    input  logic [1:0]                 dec_take,
    output logic                       dec_valid0,
    output logic                       dec_valid1,
    output logic [31:0]                dec_pc0,
    output logic [31:0]                dec_pc1,
    output logic [31:0]                dec_instr0,
    output logic [31:0]                dec_instr1,
    output logic                       stall,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] STALL_ABOVE = CW'(DEPTH - FQ_STALL_MARGIN);

    fq_state_t     state_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    fq_entry_t pair0, pair1, rd0, rd1, wdata0;
    logic      push_req, push_ok, bypass, we0, we1;
    logic [1:0] take_req, avail, take, n_wr, rd_adv;

    assign pair0 = '{pc: fetch_pc,         instr: fetch_instr0};
    assign pair1 = '{pc: fetch_pc + 32'd4, instr: fetch_instr1};

    always_comb begin
        take_req = (dec_take == 2'd3) ? 2'd2 : dec_take;
        push_req = fetch_valid && (state_reg == RUN) && !jump;
`ifdef FETCHQ_BYPASS_EN
        bypass   = push_req && (count_reg == '0);
`else
        bypass   = 1'b0;
`endif
        // Decode sees the incoming pair directly when bypassing an empty queue.
        if (bypass || count_reg >= CW'(2)) avail = 2'd2;
        else                               avail = count_reg[1:0];
        take    = (take_req < avail) ? take_req : avail;
        push_ok = push_req &&
                  (({1'b0, count_reg} + (CW+1)'(2)) <=
                   ((CW+1)'(DEPTH) + {{(CW-1){1'b0}}, take}));
        n_wr    = 2'd0;
        if (push_ok) n_wr = bypass ? (2'd2 - take) : 2'd2;
        rd_adv  = bypass ? 2'd0 : take;
        we0     = (n_wr != 2'd0);
        we1     = (n_wr == 2'd2);
        // A single write is the bypass leftover: the pair's second instruction.
        wdata0  = (n_wr == 2'd1) ? pair1 : pair0;
    end

    fetchq_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk    (clk),
        .rst    (rst),
        .we0    (we0),
        .waddr0 (wr_ptr_reg),
        .wdata0 (wdata0),
        .we1    (we1),
        .waddr1 (wr_ptr_reg + AW'(1)),
        .wdata1 (pair1),
        .raddr0 (rd_ptr_reg),
        .raddr1 (rd_ptr_reg + AW'(1)),
        .rdata0 (rd0),
        .rdata1 (rd1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= RUN;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (jump) begin
            state_reg  <= DROP;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (state_reg == DROP) state_reg <= RUN;
            wr_ptr_reg <= wr_ptr_reg + AW'(n_wr);
            rd_ptr_reg <= rd_ptr_reg + AW'(rd_adv);
            count_reg  <= count_reg + CW'(n_wr) - CW'(rd_adv);
        end
    end

    assign dec_valid0 = bypass || (count_reg != '0);
    assign dec_valid1 = bypass || (count_reg >= CW'(2));
    assign {dec_pc0, dec_instr0} = bypass ? pair0 : rd0;
    assign {dec_pc1, dec_instr1} = bypass ? pair1 : rd1;
    assign stall = (count_reg > STALL_ABOVE);
    assign count = count_reg;

endmodule
